// File: rtl/decode_ctrl_pipe.sv
// ID stage of the 5-stage core: decodes the IF/ID instruction, resolves the
// destination register, inserts load-use bubbles and registers the result into ID/EX.
module decode_ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           if_instr,
  input  logic                  if_valid,
  output logic                  id_ready,
  input  logic                  ex_ready,
  input  logic                  redirect,
  output logic                  ex_valid,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_jr,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  ex_illegal,
  output logic                  illegal_seen,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Handshake: an instruction moves from IF/ID into ID/EX on a rising edge
  // where if_valid & id_ready; EX consumes the word on an edge with ex_ready.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(2'd0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(2'd1);
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = ALU_CTRL_W'(2'd2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(2'd3);

  logic [5:0]            op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_f, rt_f, rd_f;
  logic                  unused_instr;

  assign op           = if_instr[31:26];
  assign funct        = if_instr[5:0];
  assign rs_f         = if_instr[21 +: REG_ADDR_W];
  assign rt_f         = if_instr[16 +: REG_ADDR_W];
  assign rd_f         = if_instr[11 +: REG_ADDR_W];
  assign unused_instr = ^if_instr;

  logic                  dec_branch, dec_jump, dec_jr, dec_alu_src, dec_reg_write;
  logic                  dec_mem_write, dec_mem_to_reg, dec_illegal, dec_use_rd;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  rs_used, rt_used, hazard;

  always_comb begin
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_jr         = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_illegal    = 1'b0;
    dec_use_rd     = 1'b0;
    dec_alu_ctrl   = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SUBU: begin dec_reg_write = 1'b1; dec_use_rd = 1'b1; dec_alu_ctrl = ALU_SUB;  end
          FN_NOR:  begin dec_reg_write = 1'b1; dec_use_rd = 1'b1; dec_alu_ctrl = ALU_NOR;  end
          FN_SLTU: begin dec_reg_write = 1'b1; dec_use_rd = 1'b1; dec_alu_ctrl = ALU_SLTU; end
          FN_JR:   begin dec_jr = 1'b1; dec_alu_src = 1'b1; end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_BLTZ: begin dec_branch = 1'b1; dec_alu_ctrl = ALU_SUB; end
      OP_J:    dec_jump = 1'b1;
      OP_ADDI: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_LW:   begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_mem_to_reg = 1'b1; end
      OP_SW:   begin dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
    if (!dec_reg_write)  dec_dest = '0;
    else if (dec_use_rd) dec_dest = rd_f;
    else                 dec_dest = rt_f;
  end

  logic                  ex_valid_q, ex_branch_q, ex_jump_q, ex_jr_q, ex_alu_src_q;
  logic                  ex_reg_write_q, ex_mem_write_q, ex_mem_to_reg_q, ex_illegal_q;
  logic [ALU_CTRL_W-1:0] ex_alu_ctrl_q;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_rs_q, ex_rt_q;
  logic                  ex_valid_d, ex_branch_d, ex_jump_d, ex_jr_d, ex_alu_src_d;
  logic                  ex_reg_write_d, ex_mem_write_d, ex_mem_to_reg_d, ex_illegal_d;
  logic [ALU_CTRL_W-1:0] ex_alu_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_dest_d, ex_rs_d, ex_rt_d;
  logic                  illegal_seen_q, illegal_seen_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                  ready_c, load_word, load_bubble;

  assign rs_used = (op != OP_J);
  assign rt_used = ((op == OP_RTYPE) && (funct != FN_JR)) || (op == OP_SW);
  // Only a load in EX can still be short of its data when ID needs it.
  assign hazard  = ex_valid_q && ex_mem_to_reg_q && (ex_dest_q != '0) && if_valid &&
                   ((rs_used && (ex_dest_q == rs_f)) || (rt_used && (ex_dest_q == rt_f)));

  always_comb begin
    ready_c     = 1'b0;
    load_word   = 1'b0;
    load_bubble = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      ready_c     = 1'b1;
      load_bubble = 1'b1;
      if (if_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (!ex_ready) begin
      ready_c = 1'b0;
    end else if (hazard) begin
      load_bubble = 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      ready_c     = 1'b1;
      load_word   = if_valid;
      load_bubble = !if_valid;
    end
  end

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_branch_d     = ex_branch_q;
    ex_jump_d       = ex_jump_q;
    ex_jr_d         = ex_jr_q;
    ex_alu_src_d    = ex_alu_src_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_mem_to_reg_d = ex_mem_to_reg_q;
    ex_illegal_d    = ex_illegal_q;
    ex_alu_ctrl_d   = ex_alu_ctrl_q;
    ex_dest_d       = ex_dest_q;
    ex_rs_d         = ex_rs_q;
    ex_rt_d         = ex_rt_q;
    if (load_word) begin
      ex_valid_d      = 1'b1;
      ex_branch_d     = dec_branch;
      ex_jump_d       = dec_jump;
      ex_jr_d         = dec_jr;
      ex_alu_src_d    = dec_alu_src;
      ex_reg_write_d  = dec_reg_write;
      ex_mem_write_d  = dec_mem_write;
      ex_mem_to_reg_d = dec_mem_to_reg;
      ex_illegal_d    = dec_illegal;
      ex_alu_ctrl_d   = dec_alu_ctrl;
      ex_dest_d       = dec_dest;
      ex_rs_d         = rs_f;
      ex_rt_d         = rt_f;
    end else if (load_bubble) begin
      ex_valid_d      = 1'b0;
      ex_branch_d     = 1'b0;
      ex_jump_d       = 1'b0;
      ex_jr_d         = 1'b0;
      ex_alu_src_d    = 1'b0;
      ex_reg_write_d  = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_mem_to_reg_d = 1'b0;
      ex_illegal_d    = 1'b0;
      ex_alu_ctrl_d   = '0;
      ex_dest_d       = '0;
      ex_rs_d         = '0;
      ex_rt_d         = '0;
    end
    illegal_seen_d = illegal_seen_q || (ex_valid_q && ex_illegal_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_jump_q       <= 1'b0;
      ex_jr_q         <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_illegal_q    <= 1'b0;
      ex_alu_ctrl_q   <= '0;
      ex_dest_q       <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      illegal_seen_q  <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_branch_q     <= ex_branch_d;
      ex_jump_q       <= ex_jump_d;
      ex_jr_q         <= ex_jr_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_illegal_q    <= ex_illegal_d;
      ex_alu_ctrl_q   <= ex_alu_ctrl_d;
      ex_dest_q       <= ex_dest_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      illegal_seen_q  <= illegal_seen_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  // Gated by rst_n so nothing is accepted while the pipe is held in reset.
  assign id_ready      = rst_n && ready_c;
  assign ex_valid      = ex_valid_q;
  assign ex_branch     = ex_branch_q;
  assign ex_jump       = ex_jump_q;
  assign ex_jr         = ex_jr_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_illegal    = ex_illegal_q;
  assign ex_alu_ctrl   = ex_alu_ctrl_q;
  assign ex_dest       = ex_dest_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign illegal_seen  = illegal_seen_d;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: decode table, load-use bubbles,
// redirect priority, back-pressure hold, illegal tracking and counter saturation.
module tb_decode_ctrl_pipe;

  localparam logic [31:0] I_SUBU  = 32'h010B5023;
  localparam logic [31:0] I_LW    = 32'h8D280000;
  localparam logic [31:0] I_ADDI  = 32'h21280004;
  localparam logic [31:0] I_SW    = 32'hAD280000;
  localparam logic [31:0] I_NOR   = 32'h012A5827;
  localparam logic [31:0] I_SLTU  = 32'h012A582B;
  localparam logic [31:0] I_JR    = 32'h03E00008;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_BLTZ  = 32'h05200003;
  localparam logic [31:0] I_ILL   = 32'hE8000008;

  logic        clk, rst_n;
  logic [31:0] if_instr;
  logic        if_valid, ex_ready, redirect, id_ready;
  logic        ex_valid, ex_branch, ex_jump, ex_jr, ex_alu_src;
  logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_illegal, illegal_seen;
  logic [1:0]  ex_alu_ctrl;
  logic [4:0]  ex_dest, ex_rs, ex_rt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_id_ready, s_valid, s_branch, s_jump, s_jr, s_alu_src;
  logic        s_reg_write, s_mem_write, s_mem_to_reg, s_illegal, s_illegal_seen;
  logic [1:0]  s_alu_ctrl;
  logic [4:0]  s_dest, s_rs, s_rt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [25:0] ex_word;
  logic [25:0] exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;

  assign ex_word = {ex_valid, ex_branch, ex_jump, ex_jr, ex_alu_src, ex_reg_write,
                    ex_mem_write, ex_mem_to_reg, ex_illegal, ex_alu_ctrl, ex_dest, ex_rs, ex_rt};

  decode_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .id_ready(id_ready), .ex_ready(ex_ready), .redirect(redirect),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jr(ex_jr),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_ctrl(ex_alu_ctrl), .ex_dest(ex_dest),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_illegal(ex_illegal), .illegal_seen(illegal_seen),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  decode_ctrl_pipe #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .id_ready(s_id_ready), .ex_ready(ex_ready), .redirect(redirect),
    .ex_valid(s_valid), .ex_branch(s_branch), .ex_jump(s_jump), .ex_jr(s_jr),
    .ex_alu_src(s_alu_src), .ex_reg_write(s_reg_write), .ex_mem_write(s_mem_write),
    .ex_mem_to_reg(s_mem_to_reg), .ex_alu_ctrl(s_alu_ctrl), .ex_dest(s_dest),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_illegal(s_illegal), .illegal_seen(s_illegal_seen),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode, word packed as {valid, br, j, jr, asrc, rw, mw, m2r, ill, alu, dest, rs, rt}
  function automatic logic [25:0] model(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [8:0] c;
    logic [1:0] alu;
    logic [4:0] dest;
    op = i[31:26];
    fn = i[5:0];
    c = 9'b0; alu = 2'd0; dest = 5'd0;
    if (op == 6'h00 && fn == 6'h23)      begin c = 9'b00000_1000; alu = 2'd1; dest = i[15:11]; end
    else if (op == 6'h00 && fn == 6'h27) begin c = 9'b00000_1000; alu = 2'd2; dest = i[15:11]; end
    else if (op == 6'h00 && fn == 6'h2B) begin c = 9'b00000_1000; alu = 2'd3; dest = i[15:11]; end
    else if (op == 6'h00 && fn == 6'h08) c = 9'b00011_0000;
    else if (op == 6'h01)                begin c = 9'b01000_0000; alu = 2'd1; end
    else if (op == 6'h02)                c = 9'b00100_0000;
    else if (op == 6'h08)                begin c = 9'b00001_1000; dest = i[20:16]; end
    else if (op == 6'h23)                begin c = 9'b00001_1010; dest = i[20:16]; end
    else if (op == 6'h2B)                c = 9'b00001_0100;
    else                                 c = 9'b00000_0001;
    c[8] = 1'b1;
    return {c, alu, dest, i[25:21], i[20:16]};
  endfunction

  // driver: one clock of stimulus; scoreboard push on accept, pop on EX load
  task automatic cycle(input logic [31:0] instr, input logic v, input logic er,
                       input logic rd, input logic exp_rdy);
    logic        rdy, loaded;
    logic [25:0] prev, exp_w;
    @(negedge clk);
    if_instr = instr; if_valid = v; ex_ready = er; redirect = rd;
    #1;
    rdy  = id_ready;
    prev = ex_word;
    check_eq("id_ready", {31'b0, rdy}, {31'b0, exp_rdy});
    loaded = 1'b0;
    if (v && rdy && !rd) begin
      exp_q.push_back(model(instr));
      loaded = 1'b1;
    end
    @(posedge clk);
    #1;
    if (loaded) begin
      exp_w = exp_q.pop_front();
      check_eq("ex_word", {6'b0, ex_word}, {6'b0, exp_w});
    end else if (rd || er) begin
      check_eq("bubble", {6'b0, ex_word}, 32'h0);
    end else begin
      check_eq("hold", {6'b0, ex_word}, {6'b0, prev});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_valid = 1'b0; ex_ready = 1'b1; redirect = 1'b0; if_instr = 32'h0;
    #1;
    check_eq("rst_word", {6'b0, ex_word}, 32'h0);
    check_eq("rst_ready", {31'b0, id_ready}, 32'h0);
    check_eq("rst_seen", {31'b0, illegal_seen}, 32'h0);
    check_eq("rst_stall", {16'b0, stall_cnt}, 32'h0);
    check_eq("rst_flush", {16'b0, flush_cnt}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; ex_ready = 1'b1; redirect = 1'b0; if_instr = 32'h0;
    do_reset();

    cycle(I_SUBU, 1, 1, 0, 1);
    check_eq("subu_dest", {27'b0, ex_dest}, 32'd10);
    check_eq("subu_rs", {27'b0, ex_rs}, 32'd8);
    check_eq("subu_rt", {27'b0, ex_rt}, 32'd11);
    check_eq("subu_alu", {30'b0, ex_alu_ctrl}, 32'd1);

    cycle(I_LW,   1, 1, 0, 1);
    cycle(I_SUBU, 1, 1, 0, 0);
    check_eq("stall_one", {16'b0, stall_cnt}, 32'd1);
    cycle(I_SUBU, 1, 1, 0, 1);

    cycle(I_LW,   1, 1, 0, 1);
    cycle(I_ADDI, 1, 1, 0, 1);
    check_eq("no_stall", {16'b0, stall_cnt}, 32'd1);

    cycle(I_SUBU, 1, 1, 1, 1);
    check_eq("flush_one", {16'b0, flush_cnt}, 32'd1);
    cycle(I_LW,   1, 1, 0, 1);
    cycle(I_SUBU, 1, 0, 1, 1);
    check_eq("flush_two", {16'b0, flush_cnt}, 32'd2);
    check_eq("redir_nostall", {16'b0, stall_cnt}, 32'd1);

    cycle(I_SW, 1, 1, 0, 1);
    for (int k = 0; k < 3; k++) cycle(I_ADDI, 1, 0, 0, 0);
    cycle(I_ADDI, 1, 1, 0, 1);

    cycle(I_NOR,  1, 1, 0, 1);
    cycle(I_SLTU, 1, 1, 0, 1);
    cycle(I_JR,   1, 1, 0, 1);
    cycle(I_J,    1, 1, 0, 1);
    cycle(I_BLTZ, 1, 1, 0, 1);
    cycle({$urandom_range(0, 31), 26'h0}, 0, 1, 0, 1);

    cycle(I_ILL, 1, 1, 0, 1);
    check_eq("ill_flag", {31'b0, ex_illegal}, 32'd1);
    check_eq("ill_seen", {31'b0, illegal_seen}, 32'd1);
    cycle(I_ADDI, 0, 1, 0, 1);
    cycle(I_ADDI, 1, 1, 0, 1);
    check_eq("ill_sticky", {31'b0, illegal_seen}, 32'd1);
    do_reset();

    for (int k = 0; k < 5; k++) begin
      cycle(I_LW,   1, 1, 0, 1);
      cycle(I_SUBU, 1, 1, 0, 0);
      cycle(I_SUBU, 1, 1, 0, 1);
    end
    check_eq("stall_five", {16'b0, stall_cnt}, 32'd5);
    check_eq("stall_sat", {30'b0, s_stall_cnt}, 32'd3);

    cycle(I_LW, 1, 1, 0, 1);
    @(negedge clk);
    if_instr = I_SUBU; if_valid = 1'b1; ex_ready = 1'b1; redirect = 1'b0;
    #1;
    check_eq("mid_hazard", {31'b0, id_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_word", {6'b0, ex_word}, 32'h0);
    check_eq("mid_rst_ready", {31'b0, id_ready}, 32'h0);
    check_eq("mid_rst_stall", {16'b0, stall_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
